// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-requester priority arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    // One-hot encode a requester index.
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/arb_pri_sel.sv
// Combinational 4-bit priority select with a movable top-priority index.
// Search order is top, top-1, top-2, top-3 (modulo 4).
module arb_pri_sel
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    input  logic [ID_W-1:0]    top,
    output logic [ID_W-1:0]    id,
    output logic               hit
);

    logic [ID_W-1:0] idx;

    // Walk from lowest to highest priority so the last hit written wins.
    always_comb begin
        id  = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = top - ID_W'(k);
            if (vec[idx]) begin
                id  = idx;
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_priority_arbiter.sv
// Sequential 4-requester arbiter with hold timeout and a dead cycle between owners.
// Build option: ARB_ROUND_ROBIN_EN enables rotating priority; undefined gives fixed 3>2>1>0.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no owner, arbitrate any request
// ST_GRANT   | owner holds gnt until it drops req or the hold limit is hit
// ST_RELEASE | dead cycle, gnt=0, arbitrate for the next owner
module req_priority_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t         state, state_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0] excl, excl_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic               timeout_nxt;

    logic [NUM_REQ-1:0] masked, sel_vec;
    logic [ID_W-1:0]    win_id, top;
    logic               win_hit;
    logic               owner_req, at_limit;

    // A timed-out owner is skipped unless it is the only requester.
    assign masked    = req & ~excl;
    assign sel_vec   = (masked != '0) ? masked : req;
    assign owner_req = req[gnt_id];
    assign at_limit  = (hold_cnt == HOLD_LAST);
    assign gnt_valid = |gnt;

    arb_pri_sel u_pri_sel (
        .vec (sel_vec),
        .top (top),
        .id  (win_id),
        .hit (win_hit)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Remember the last owner; it becomes the lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (state != ST_GRANT && state_nxt == ST_GRANT)
            rr_ptr <= win_id;
    end

    assign top = rr_ptr - ID_W'(1);
`else
    assign top = ID_W'(3);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    state_nxt = win_hit ? ST_GRANT : ST_IDLE;
            ST_GRANT:   state_nxt = (!owner_req || at_limit) ? ST_RELEASE : ST_GRANT;
            ST_RELEASE: state_nxt = win_hit ? ST_GRANT : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter and exclusion mask.
    always_comb begin
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        timeout_nxt = 1'b0;
        excl_nxt    = excl;
        hold_nxt    = hold_cnt;
        case (state)
            ST_GRANT: begin
                if (!owner_req) begin
                    gnt_nxt  = '0;
                    excl_nxt = '0;
                end else if (at_limit) begin
                    gnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    excl_nxt    = onehot4(gnt_id);
                end else begin
                    // Leaving at the limit means the counter never wraps.
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                gnt_nxt  = '0;
                excl_nxt = '0;
                if (win_hit) begin
                    gnt_nxt    = onehot4(win_id);
                    gnt_id_nxt = win_id;
                    hold_nxt   = '0;
                end
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
            excl     <= '0;
            hold_cnt <= '0;
        end else begin
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            timeout  <= timeout_nxt;
            excl     <= excl_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Directed self-checking bench for req_priority_arbiter (MAX_HOLD=15).
module tb_req_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    req_priority_arbiter #(.MAX_HOLD(15), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int run;
        int tos;
        int bad;
        int bursts[$];
        int exp_order[5];
        logic [1:0] owner;

        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_no_req", 32'(gnt), 32'h0);

        // Async reset in the middle of a grant to owner 2.
        req = 4'b0100;
        step();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_id", 32'(gnt_id), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_gnt", 32'(gnt), 32'h0);
        check("t1_async_valid", 32'(gnt_valid), 32'h0);
        check("t1_async_id", 32'(gnt_id), 32'h0);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        step();

        // Priority 2 over 0, dead cycle, then 0.
        req = 4'b0101;
        step();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_id", 32'(gnt_id), 32'h2);
        check("t2_valid", 32'(gnt_valid), 32'h1);
        req = 4'b0001;
        step();
        check("t2_dead", 32'(gnt), 32'h0);
        check("t2_dead_valid", 32'(gnt_valid), 32'h0);
        check("t2_dead_id_hold", 32'(gnt_id), 32'h2);
        step();
        check("t2_gnt0", 32'(gnt), 32'h1);
        check("t2_id0", 32'(gnt_id), 32'h0);
        req = 4'b0000;
        step();
        step();

        // Owner 1 times out after 15 cycles, masked in favour of 0.
        req = 4'b0011;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (gnt !== 4'b0010 || timeout !== 1'b0) bad++;
        end
        check("t3_hold15", 32'(bad), 32'h0);
        step();
        check("t3_to_gnt", 32'(gnt), 32'h0);
        check("t3_to_pulse", 32'(timeout), 32'h1);
        step();
        check("t3_next_gnt", 32'(gnt), 32'h1);
        check("t3_next_id", 32'(gnt_id), 32'h0);
        check("t3_to_drop", 32'(timeout), 32'h0);
        req = 4'b0000;
        step();
        step();

        // Sole requester 3 held long enough for bursts 15,15,10.
        req = 4'b1000;
        run = 0;
        tos = 0;
        bad = 0;
        for (int i = 0; i < 42; i++) begin
            step();
            if (gnt === 4'b1000) run++;
            else begin
                if (gnt !== 4'b0000) bad++;
                if (run > 0) bursts.push_back(run);
                run = 0;
            end
            if (timeout === 1'b1) tos++;
        end
        req = 4'b0000;
        step();
        if (run > 0) bursts.push_back(run);
        check("t4_gnt_shape", 32'(bad), 32'h0);
        check("t4_nbursts", 32'(bursts.size()), 32'd3);
        check("t4_burst0", 32'(bursts.size() > 0 ? bursts[0] : -1), 32'd15);
        check("t4_burst1", 32'(bursts.size() > 1 ? bursts[1] : -1), 32'd15);
        check("t4_burst2", 32'(bursts.size() > 2 ? bursts[2] : -1), 32'd10);
        check("t4_timeouts", 32'(tos), 32'd2);
        check("t4_release_to", 32'(timeout), 32'h0);
        step();

        // No preemption of owner 0 by a later req[3].
        req = 4'b0001;
        step();
        check("t5_gnt0", 32'(gnt), 32'h1);
        req = 4'b1001;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (gnt !== 4'b0001) bad++;
        end
        check("t5_no_preempt", 32'(bad), 32'h0);
        req = 4'b1000;
        step();
        check("t5_dead", 32'(gnt), 32'h0);
        step();
        check("t5_gnt3", 32'(gnt), 32'h8);
        check("t5_id3", 32'(gnt_id), 32'h3);
        req = 4'b0000;
        step();
        step();

        // All requesting, each owner releases after one cycle and re-raises.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{3, 2, 1, 0, 3};
`else
        exp_order = '{3, 3, 3, 3, 3};
`endif
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("t6_id%0d", g), 32'(gnt_id), 32'(exp_order[g]));
            check($sformatf("t6_gnt%0d", g), 32'(gnt), 32'(4'b0001 << exp_order[g]));
            owner = gnt_id;
            req = 4'b1111 & ~(4'b0001 << owner);
            step();
            check($sformatf("t6_dead%0d", g), 32'(gnt), 32'h0);
            req = 4'b1111;
        end
        req = 4'b0000;
        step();
        step();
        check("end_idle", 32'(gnt_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
